// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian 16-bit instructions and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int MEM_DEPTH = 512,
    parameter int CNT_W     = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_load_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        program_mem_write_en_o,
    output logic [15:0] instruction_o,
    output logic [31:0] instruction_addr_o,
    output logic        cpu_hold_o,
    output logic        fetch_valid_o,
    output logic        load_done_o,
    output logic        load_error_o
);

    // Stream handshake: a byte transfers on a rising clk_i edge where
    // byte_valid_i and byte_ready_o are both high; valid may stall indefinitely.
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI,
        S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_e;

    state_e           state_q, state_d, end_state;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic [15:0]      instr_q, instr_d;
    logic             accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    assign accept = byte_valid_i & byte_ready_o;

`ifdef LOADER_CHECKSUM_EN
    assign end_state = S_CHECK;
`else
    assign end_state = S_DONE;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        instr_d = instr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_load_i) begin
                    state_d = S_LEN_LO;
                    index_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    count_d = CNT_W'(byte_i);
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    count_d = CNT_W'({byte_i, count_q[7:0]});
                    if (count_d == '0) begin
                        state_d = end_state;
                    end else if (count_d > CNT_W'(MEM_DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    instr_d = {instr_q[15:8], byte_i};
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_i;
`endif
                    state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    instr_d = {byte_i, instr_q[7:0]};
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ byte_i;
`endif
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                index_d = index_q + 1'b1;
                state_d = (index_d == count_q) ? end_state : S_DATA_LO;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (byte_i == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q                <= S_IDLE;
            count_q                <= '0;
            index_q                <= '0;
            instr_q                <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q                 <= 8'h00;
`endif
            byte_ready_o           <= 1'b0;
            program_mem_write_en_o <= 1'b0;
            instruction_o          <= '0;
            instruction_addr_o     <= '0;
            cpu_hold_o             <= 1'b1;
            fetch_valid_o          <= 1'b0;
            load_done_o            <= 1'b0;
            load_error_o           <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            instr_q <= instr_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
            byte_ready_o <= (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                            (state_d == S_DATA_LO) || (state_d == S_DATA_HI) ||
                            (state_d == S_CHECK);
            program_mem_write_en_o <= (state_d == S_WRITE);
            if (state_d == S_WRITE) begin
                instruction_o      <= instr_d;
                instruction_addr_o <= 32'(index_q);
            end
            cpu_hold_o    <= (state_d != S_DONE);
            fetch_valid_o <= (state_d == S_DONE);
            load_done_o   <= (state_d == S_DONE);
            load_error_o  <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader, checked against a stream-level reference model.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_program_loader;
  localparam int MEM_DEPTH = 512;
  localparam int W = 48;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_load = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready_o;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;
  logic        cpu_hold_o;
  logic        fetch_valid_o;
  logic        load_done_o;
  logic        load_error_o;

  int n_tests = 0;
  int n_fail = 0;
  int ready_in_write = 0;

  logic [7:0]   stream_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  program_loader #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(16)) dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n),
    .start_load_i           (start_load),
    .byte_i                 (byte_in),
    .byte_valid_i           (byte_valid),
    .byte_ready_o           (byte_ready_o),
    .program_mem_write_en_o (program_mem_write_en_o),
    .instruction_o          (instruction_o),
    .instruction_addr_o     (instruction_addr_o),
    .cpu_hold_o             (cpu_hold_o),
    .fetch_valid_o          (fetch_valid_o),
    .load_done_o            (load_done_o),
    .load_error_o           (load_error_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write monitor: one entry per strobed cycle
  always @(negedge clk) begin
    if (program_mem_write_en_o) begin
      got_q.push_back({instruction_addr_o, instruction_o});
      if (byte_ready_o) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: what a stream should produce, from the stream's own rules
  task automatic model_load(output bit err, output int used);
    int cnt;
    logic [7:0] x;
    exp_q.delete();
    err = 1'b0;
    x = 8'h00;
    cnt = int'({stream_q[1], stream_q[0]});
    used = 2;
    if (cnt > MEM_DEPTH) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back({32'(i), stream_q[3 + 2*i], stream_q[2 + 2*i]});
      x = x ^ stream_q[2 + 2*i] ^ stream_q[3 + 2*i];
    end
    used = 2 + 2*cnt;
`ifdef LOADER_CHECKSUM_EN
    err = (stream_q[used] != x);
    used++;
`endif
  endtask

  task automatic build_random(input int cnt);
    logic [7:0] x, b;
    x = 8'h00;
    stream_q.delete();
    stream_q.push_back(cnt[7:0]);
    stream_q.push_back(cnt[15:8]);
    if (cnt <= MEM_DEPTH) begin
      for (int i = 0; i < 2*cnt; i++) begin
        b = 8'($urandom);
        stream_q.push_back(b);
        x = x ^ b;
      end
`ifdef LOADER_CHECKSUM_EN
      stream_q.push_back(($urandom_range(0, 3) == 0) ? ~x : x);
`endif
    end
  endtask

  // driver: entered and left on a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("byte_accept_in_time", W'(waited < 50), W'(1));
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
  endtask

  task automatic run_load(input string tag, input int gap_max, input int mid_start_at, input bit lat_chk);
    bit err;
    int used, w;
    got_q.delete();
    model_load(err, used);
    pulse_start();
    for (int k = 0; k < used; k++) begin
      if (k == mid_start_at) pulse_start();
      send_byte(stream_q[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
`ifndef LOADER_CHECKSUM_EN
    if (lat_chk) begin
      check({tag, "_last_strobe"}, W'(program_mem_write_en_o), W'(1));
      check({tag, "_done_not_yet"}, W'(load_done_o), W'(0));
      @(negedge clk);
      check({tag, "_strobe_one_cycle"}, W'(program_mem_write_en_o), W'(0));
      check({tag, "_done_next_cycle"}, W'(load_done_o), W'(1));
      check({tag, "_fetch_valid_next"}, W'(fetch_valid_o), W'(1));
    end
`else
    if (lat_chk) check({tag, "_no_strobe_after"}, W'(program_mem_write_en_o), W'(0));
`endif
    w = 0;
    while (!(load_done_o || load_error_o) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_end_in_time"}, W'(w < 20), W'(1));
    repeat (2) @(negedge clk);
    check({tag, "_done"}, W'(load_done_o), W'(!err));
    check({tag, "_error"}, W'(load_error_o), W'(err));
    check({tag, "_hold"}, W'(cpu_hold_o), W'(err));
    check({tag, "_fetch_valid"}, W'(fetch_valid_o), W'(!err));
    check({tag, "_ready_idle"}, W'(byte_ready_o), W'(0));
    check({tag, "_ready_low_in_write"}, W'(ready_in_write), W'(0));
    check({tag, "_n_writes"}, W'(got_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_write"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    // reset state and idle
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_hold", W'(cpu_hold_o), W'(1));
    check("rst_fetch_valid", W'(fetch_valid_o), W'(0));
    check("rst_ready", W'(byte_ready_o), W'(0));
    check("rst_strobe", W'(program_mem_write_en_o), W'(0));
    check("rst_done", W'(load_done_o), W'(0));
    check("rst_error", W'(load_error_o), W'(0));
    check("rst_no_writes", W'(got_q.size()), W'(0));

    // two-instruction load, valid every cycle
    stream_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56);
`endif
    run_load("basic", 0, -1, 1'b1);

    // same stream with gaps and an ignored mid-load start
    run_load("gaps", 3, 3, 1'b0);

    // oversize length, then zero-length recovery
    stream_q = '{8'h01, 8'h02};
    run_load("len513", 0, -1, 1'b0);
    stream_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'h00);
`endif
    run_load("len0", 1, -1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    stream_q = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h26};
    run_load("cks_good", 0, -1, 1'b0);
    stream_q = '{8'h01, 8'h00, 8'h34, 8'h12, 8'h27};
    run_load("cks_bad", 0, -1, 1'b0);
`endif

    // asynchronous reset after the first write of a three-instruction load
    build_random(3);
    got_q.delete();
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(stream_q[k], 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_hold", W'(cpu_hold_o), W'(1));
    check("async_rst_ready", W'(byte_ready_o), W'(0));
    check("async_rst_strobe", W'(program_mem_write_en_o), W'(0));
    check("async_rst_one_write", W'(got_q.size()), W'(1));
    if (got_q.size() > 0)
      check("async_rst_first_write", got_q[0], {32'd0, stream_q[3], stream_q[2]});
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stream_q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(8'hAA ^ 8'hBB);
`endif
    run_load("after_rst", 0, -1, 1'b0);

    // full-depth load: last index 511
    build_random(MEM_DEPTH);
    run_load("full_depth", 0, -1, 1'b0);

    // randomized loads
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 5) == 0) build_random(int'($urandom_range(MEM_DEPTH + 1, 1000)));
      else build_random(int'($urandom_range(0, 8)));
      run_load("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder of the instruction memory stage.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit Thumb instructions.
- Writes each instruction into instruction memory via the write-enable/address/data path, holding the core in reset-equivalent idle until the load completes.
- Once the load completes, deasserts hold and raises the fetch valid so the core begins execution at PC 0.

Parameters:
- MEM_DEPTH, 512, instruction memory depth in halfwords; max loadable count.
- CNT_W, 16, width of the length field and the internal counters.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- start_load_i  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- byte_i  in  8  stream data byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader can accept a byte; transfer when valid&ready on a rising edge.
- program_mem_write_en_o  out  1  instruction memory write strobe.
- instruction_o  out  16  instruction to write.
- instruction_addr_o  out  32  halfword index, zero-extended.
- cpu_hold_o  out  1  high keeps the pipeline stalled/flushed.
- fetch_valid_o  out  1  drives fetch is_valid input; equals ~cpu_hold_o.
- load_done_o  out  1  high in DONE.
- load_error_o  out  1  high in ERROR, sticky.

Behaviour:
- Reset (async, reset_n_i=0): state=IDLE, all outputs 0 except cpu_hold_o=1; counters, address and data cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK (feature only), DONE, ERROR.
- IDLE/DONE/ERROR: on start_load_i -> LEN_LO, address:=0, error cleared, cpu_hold_o:=1.
- byte_ready_o=1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK; 0 otherwise.
- A state advances only on an accepted byte. Stalls on byte_valid_i=0 are unbounded; no timeout.
- LEN_LO: count[7:0]:=byte.
- LEN_HI: count[15:8]:=byte; then:
  - count==0 -> DONE (or CHECK when the feature is enabled);
  - count>MEM_DEPTH -> ERROR;
  - otherwise -> DATA_LO.
- DATA_LO: instr[7:0]:=byte. DATA_HI: instr[15:8]:=byte -> WRITE.
- WRITE: exactly one cycle with program_mem_write_en_o=1, instruction_o=instr, instruction_addr_o=current index.
  - Next cycle: index+1.
  - If index+1==count -> DONE (or CHECK); else -> DATA_LO.
- program_mem_write_en_o is 0 in every state except WRITE.
- instruction_o and instruction_addr_o hold their values outside WRITE.
- DONE: cpu_hold_o=0, fetch_valid_o=1, load_done_o=1; byte_ready_o=0, so further bytes are not consumed.
- ERROR: cpu_hold_o=1, load_error_o=1, no writes. Exit via start_load_i or reset only.
- start_load_i while in LEN_*/DATA_*/WRITE/CHECK is ignored.
- Reset mid-load returns to IDLE immediately. Memory contents are left partially written; a fresh load is required.
- Last index written is count-1 (max MEM_DEPTH-1 = 511). The index never wraps.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - A running XOR of every data byte (length bytes excluded) is kept, cleared on start.
  - After the last WRITE, or immediately when count==0, the state is CHECK and accepts one byte.
  - Byte equals the running XOR -> DONE; otherwise -> ERROR.
- LOADER_CHECKSUM_EN undefined: no CHECK state, no extra byte; loads end directly in DONE.

Test Plan:
- Reset then idle 5 cycles -> cpu_hold_o=1, fetch_valid_o=0, byte_ready_o=0, no write strobe.
- start_load_i, stream 02 00 34 12 78 56, valid every cycle -> writes addr0=0x1234 then addr1=0x5678, one-cycle strobe each; DONE and fetch_valid_o=1 the cycle after the second WRITE.
- Same stream with byte_valid_i toggling 1/0 and gaps of 3 cycles -> identical writes and order; byte_ready_o low during WRITE.
- Length bytes 01 02 (count 513) -> ERROR, load_error_o=1, zero writes. Then start_load_i with 00 00 -> DONE, error cleared.
- Assert reset_n_i low after the first data write of a 3-instruction load -> asynchronous return to IDLE, cpu_hold_o=1. A new load of 01 00 AA BB writes 0xBBAA to addr0.
- LOADER_CHECKSUM_EN defined, stream 01 00 34 12 26 -> DONE. Same stream with final byte 27 -> ERROR.
